// File: rtl/frame_buffer_dbl_if.sv
// Pixel bus between the frame buffer and its two clients: the arbiter
// writes pixels into the back bank, and the video scan-out reads pixels
// from the front bank.
interface frame_buffer_dbl_if #(
    parameter int PIX_W  = 1,
    parameter int ADDR_W = 20
);
    logic              arb_we;
    logic [ADDR_W-1:0] arb_addr;
    logic [PIX_W-1:0]  arb_din;
    logic              arb_ready;
    logic              vga_re;
    logic [ADDR_W-1:0] vga_addr;
    logic [PIX_W-1:0]  vga_dout;
    logic              vga_dvalid;

    // The client side, which drives write and read requests.
    modport master (
        output arb_we, arb_addr, arb_din, vga_re, vga_addr,
        input  arb_ready, vga_dout, vga_dvalid
    );

    // The frame buffer side, which accepts requests and returns read data.
    modport slave (
        input  arb_we, arb_addr, arb_din, vga_re, vga_addr,
        output arb_ready, vga_dout, vga_dvalid
    );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame buffer. Both banks share one RAM of 2*DEPTH
// pixels, and the bank selects the upper or lower half. The arbiter
// writes the back bank while video reads the front bank. The banks swap
// only on frame_start. A clear engine fills the back bank with a
// constant value, one pixel per cycle.
module frame_buffer_dbl #(
    parameter int PIX_W  = 1,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 786432
) (
    input  logic                clk,
    input  logic                rst_n,
    frame_buffer_dbl_if.slave   bus,
    input  logic                frame_start,
    input  logic                swap_req,
    output logic                swap_pending,
    output logic                front_sel,
    input  logic                clr_start,
    input  logic [PIX_W-1:0]    clr_val,
    output logic                clr_busy
);

    localparam int                MEM_PW    = $clog2(2 * DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    clr_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_bank;
    logic [PIX_W-1:0]  clr_fill;

    logic [PIX_W-1:0]  mem [0:2*DEPTH-1];

    logic              wr_en;
    logic [MEM_PW-1:0] wr_ptr;
    logic [PIX_W-1:0]  wr_data;
    logic [MEM_PW-1:0] rd_ptr;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_vld1;
    logic              rd_oor1;
    logic              arb_in_range;
    logic              vga_in_range;
    logic              do_swap;

    // Map a bank and pixel address into the shared RAM. Bank 1 occupies
    // the upper DEPTH entries.
    function automatic logic [MEM_PW-1:0] bank_ptr(input logic bank,
                                                   input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] full;
        full = {1'b0, addr} + (bank ? DEPTH_X : '0);
        return MEM_PW'(full);
    endfunction

    assign arb_in_range = ({1'b0, bus.arb_addr} < DEPTH_X);
    assign vga_in_range = ({1'b0, bus.vga_addr} < DEPTH_X);
    assign do_swap      = frame_start && swap_pending && !clr_busy;

    // An out-of-range read still reads a legal location; its data is
    // replaced with zero later in the pipeline.
    assign rd_ptr = bank_ptr(front_sel, vga_in_range ? bus.vga_addr : '0);

    // Select the single write port. The clear engine owns the port while
    // it runs. Otherwise an accepted, in-range arbiter write uses the port.
    always_comb begin
        wr_en   = 1'b0;
        wr_ptr  = '0;
        wr_data = '0;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_ptr  = bank_ptr(clr_bank, clr_cnt);
            wr_data = clr_fill;
        end else if (bus.arb_we && bus.arb_ready && arb_in_range) begin
            wr_en   = 1'b1;
            wr_ptr  = bank_ptr(!front_sel, bus.arb_addr);
            wr_data = bus.arb_din;
        end
    end

    // Block RAM: one synchronous write port and one synchronous read port,
    // with no reset so the tools can infer a real memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
        rd_data <= mem[rd_ptr];
    end

    // Two-stage read pipeline. The valid and range flags follow the RAM
    // read, and the output register holds its value while no read is in
    // flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld1        <= 1'b0;
            rd_oor1        <= 1'b0;
            bus.vga_dvalid <= 1'b0;
            bus.vga_dout   <= '0;
        end else begin
            rd_vld1        <= bus.vga_re;
            rd_oor1        <= !vga_in_range;
            bus.vga_dvalid <= rd_vld1;
            if (rd_vld1) begin
                bus.vga_dout <= rd_oor1 ? '0 : rd_data;
            end
        end
    end

    // Track a requested swap and carry it out on the next frame_start that
    // is not blocked by a running clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (do_swap) begin
            front_sel    <= !front_sel;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // Clear engine: latch the fill value and the back bank, then write
    // DEPTH consecutive pixels. The arbiter is stalled while this runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            clr_bank      <= 1'b0;
            clr_fill      <= '0;
            clr_busy      <= 1'b0;
            bus.arb_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        clr_fill      <= clr_val;
                        clr_bank      <= !front_sel;
                        clr_cnt       <= '0;
                        state         <= CLEAR;
                        clr_busy      <= 1'b1;
                        bus.arb_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state         <= IDLE;
                        clr_busy      <= 1'b0;
                        bus.arb_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_buffer_dbl.md
Name: frame_buffer_dbl

Overview:
Parametrised, single-clock, double-buffered frame buffer. It replaces the fixed 1-bit x 786432 buffer with two banks of DEPTH x PIX_W pixels. The arbiter writes the back bank while video reads the front bank. Banks swap only on a frame boundary, and a hardware clear engine fills the back bank with a constant pixel value.

Parameters:
PIX_W, 1, bits per pixel
ADDR_W, 20, pixel address width
DEPTH, 786432, pixels per bank; must be <= 2^ADDR_W

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
arb_we  in  1  arbiter write strobe to back bank
arb_addr  in  ADDR_W  arbiter write address
arb_din  in  PIX_W  arbiter write data
arb_ready  out  1  high when arbiter writes are accepted
vga_re  in  1  video read request from front bank
vga_addr  in  ADDR_W  video read address
vga_dout  out  PIX_W  read data
vga_dvalid  out  1  vga_dout valid this cycle
frame_start  in  1  one-cycle pulse at start of vertical blank
swap_req  in  1  request front/back swap at next frame_start
swap_pending  out  1  swap requested, not yet performed
front_sel  out  1  bank currently displayed (0 or 1)
clr_start  in  1  start clearing back bank
clr_val  in  PIX_W  fill value, sampled with clr_start
clr_busy  out  1  clear in progress

Behaviour:
- Reset (async assert, sync release): front_sel=0, swap_pending=0, clr_busy=0, arb_ready=1, vga_dout=0, vga_dvalid=0, FSM=IDLE. Memory contents are not reset.
- Back bank = ~front_sel. Writes always target the back bank; reads always target the front bank, so read/write collisions cannot occur.
- Write: accepted when arb_we && arb_ready. The pixel is written at the clock edge. arb_addr >= DEPTH: write is dropped silently.
- Read: fixed latency 2.
  - Cycle N: vga_re with vga_addr; the bank is captured at N.
  - Edge N+1: synchronous memory read.
  - Edge N+2: output register; vga_dout/vga_dvalid valid during cycle N+2.
  - Back-to-back reads give one result per cycle.
  - vga_re=0 -> vga_dvalid=0 two cycles later; vga_dout holds its last value.
  - vga_addr >= DEPTH -> vga_dout=0, vga_dvalid=1.
  - A read issued before a swap edge returns old-front data.
- Swap:
  - swap_req sets swap_pending on the next edge.
  - On a cycle with frame_start && swap_pending && !clr_busy: front_sel toggles and swap_pending clears at that edge.
  - swap_req coincident with frame_start while swap_pending=0: pending is set, and the swap occurs at the following frame_start.
  - swap_req while already pending has no additional effect.
  - frame_start while clr_busy: swap is deferred and pending is held.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: on clr_start, latch clr_val and the back-bank index, load counter=0, and go to CLEAR.
  - CLEAR: each cycle write the latched value to counter in the latched bank, then increment. After writing DEPTH-1, go to IDLE.
  - clr_busy=1 exactly DEPTH cycles, starting the cycle after clr_start.
  - arb_ready = !clr_busy. arb_we while busy is ignored and does not corrupt memory.
  - clr_start during CLEAR is ignored.
  - Counter width is ADDR_W; no wrap beyond DEPTH-1.
- Reset mid-clear: FSM returns to IDLE immediately. Partially cleared memory is left as is.
- Target: infer two simple-dual-port block RAMs (or one 2*DEPTH RAM with the bank as address MSB); no async-read memories.

Test Plan:
- Reset/idle (DEPTH=16, PIX_W=4): hold rst_n=0 -> front_sel=0, arb_ready=1, vga_dvalid=0, clr_busy=0. Then release reset.
- Write/swap/read:
  - Write 0xA to addr 3 (back bank 1), then swap_req, then frame_start -> front_sel=1.
  - vga_re addr 3 at cycle N -> vga_dout=0xA, vga_dvalid=1 at N+2.
  - Pipelined reads of addrs 0..15 -> 16 consecutive valid outputs.
- Out-of-range: write addr 20 with 0x5 -> no bank location changes. Read addr 20 -> vga_dout=0, vga_dvalid=1.
- Clear:
  - clr_start with clr_val=0x7 -> clr_busy high exactly 16 cycles, arb_ready low for the same 16 cycles.
  - arb_we to addr 2 mid-clear is ignored.
  - After swap, all 16 reads return 0x7.
- Swap timing:
  - swap_req coincident with the first frame_start -> no toggle; toggle at the second frame_start.
  - frame_start during clr_busy -> no toggle, swap_pending stays 1; toggle at the first frame_start after clr_busy falls.
- Async reset mid-clear: drop rst_n at counter=5 -> clr_busy=0 without a clock edge; after release, FSM is IDLE and new writes are accepted.
